// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   Front-of-pipeline program counter and fetch sequencer. Owns the PC
//   register and the instruction-memory request handshake. Delivers fetched
//   PCs to the IF/ID register and handles stall, branch redirect with flush,
//   and a sticky halt.
//
// Ports
//   clk          : rising-edge clock
//   rst          : asynchronous active-low reset
//   stall        : downstream hazard stall; hold PC and outputs, drop request
//   branch_taken : resolved branch/jump; redirect fetch to next_pc
//   halt         : halt request; unit parks in HALTED until reset
//   next_pc      : output of external next-PC mux (pc_inc or branch target)
//   imem_ready   : instruction memory accepts the request this cycle
//   pc_inc       : pc + STEP (mux A operand)
//   sel          : mux select, 1 = branch target
//   imem_req     : fetch request
//   imem_addr    : fetch address (current pc)
//   fetch_valid  : fetch_pc holds a valid instruction address
//   fetch_pc     : PC of the delivered instruction
//   flush        : one-cycle pulse squashing the younger IF/ID instruction
//   halted       : unit is in HALTED
module pc_fetch_unit #(
    parameter int          N        = 21,
    parameter logic [N-1:0] RESET_PC = 21'd0,
    parameter logic [N-1:0] STEP     = 21'd1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         branch_taken,
    input  logic         halt,
    input  logic [N-1:0] next_pc,
    input  logic         imem_ready,
    output logic [N-1:0] pc_inc,
    output logic         sel,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    output logic         fetch_valid,
    output logic [N-1:0] fetch_pc,
    output logic         flush,
    output logic         halted
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_WAIT   = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [N-1:0] r_pc;
    logic [N-1:0] r_fetch_pc;
    logic         r_fetch_valid;
    logic         r_flush;
    logic         w_active;

    assign w_active = (r_state == S_FETCH) || (r_state == S_WAIT);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; halt beats branch beats stall beats acceptance
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = S_FETCH;
            S_FETCH,
            S_WAIT: begin
                if (halt)              w_state_nxt = S_HALTED;
                else if (branch_taken) w_state_nxt = S_FETCH;
                else if (stall)        w_state_nxt = r_state;
                else if (imem_ready)   w_state_nxt = S_FETCH;
                else                   w_state_nxt = S_WAIT;
            end
            S_HALTED: w_state_nxt = S_HALTED;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic; a stall withdraws the request so memory sees no access
    always_comb begin
        imem_req = w_active && !stall;
        halted   = (r_state == S_HALTED);
    end

    // PC and IF/ID delivery registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc          <= RESET_PC;
            r_fetch_pc    <= '0;
            r_fetch_valid <= 1'b0;
            r_flush       <= 1'b0;
        end else begin
            r_flush <= 1'b0;
            if (w_active) begin
                if (halt) begin
                    r_fetch_valid <= 1'b0;
                end else if (branch_taken) begin
                    // Redirect: any same-cycle acceptance is discarded
                    r_pc          <= next_pc;
                    r_fetch_valid <= 1'b0;
                    r_flush       <= 1'b1;
                end else if (stall) begin
                    // Hold pc, fetch_pc and fetch_valid
                    r_pc <= r_pc;
                end else if (imem_ready) begin
                    r_fetch_pc    <= r_pc;
                    r_fetch_valid <= 1'b1;
                    r_pc          <= next_pc;
                end else begin
                    r_fetch_valid <= 1'b0;
                end
            end else begin
                r_fetch_valid <= 1'b0;
            end
        end
    end

    assign pc_inc      = r_pc + STEP;
    assign sel         = branch_taken && !halt && (r_state != S_IDLE);
    assign imem_addr   = r_pc;
    assign fetch_valid = r_fetch_valid;
    assign fetch_pc    = r_fetch_pc;
    assign flush       = r_flush;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

    localparam int N = 21;

    logic         clk = 1'b0;
    logic         rst0, rst1;
    logic         stall, branch_taken, halt, imem_ready;
    logic [N-1:0] tgt;

    logic [N-1:0] next_pc0, pc_inc0, imem_addr0, fetch_pc0;
    logic         sel0, imem_req0, fetch_valid0, flush0, halted0;

    logic [N-1:0] next_pc1, pc_inc1, imem_addr1, fetch_pc1;
    logic         sel1, imem_req1, fetch_valid1, flush1, halted1;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    // External next-PC mux (A = pc_inc, B = branch target)
    assign next_pc0 = sel0 ? tgt : pc_inc0;
    assign next_pc1 = sel1 ? tgt : pc_inc1;

    pc_fetch_unit #(.N(N), .RESET_PC(21'd0), .STEP(21'd1)) u_dut0 (
        .clk(clk), .rst(rst0), .stall(stall), .branch_taken(branch_taken),
        .halt(halt), .next_pc(next_pc0), .imem_ready(imem_ready),
        .pc_inc(pc_inc0), .sel(sel0), .imem_req(imem_req0),
        .imem_addr(imem_addr0), .fetch_valid(fetch_valid0),
        .fetch_pc(fetch_pc0), .flush(flush0), .halted(halted0)
    );

    pc_fetch_unit #(.N(N), .RESET_PC(21'h1FFFFE), .STEP(21'd1)) u_dut1 (
        .clk(clk), .rst(rst1), .stall(1'b0), .branch_taken(1'b0),
        .halt(1'b0), .next_pc(next_pc1), .imem_ready(1'b1),
        .pc_inc(pc_inc1), .sel(sel1), .imem_req(imem_req1),
        .imem_addr(imem_addr1), .fetch_valid(fetch_valid1),
        .fetch_pc(fetch_pc1), .flush(flush1), .halted(halted1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst0 = 1'b0; rst1 = 1'b0;
        stall = 1'b0; halt = 1'b0; imem_ready = 1'b1;
        branch_taken = 1'b1; tgt = 21'd0;
        #3;
        // Reset state; sel masked in IDLE even with branch_taken high
        chk("rst_fv",    fetch_valid0, 0);
        chk("rst_fpc",   fetch_pc0,    0);
        chk("rst_flush", flush0,       0);
        chk("rst_halt",  halted0,      0);
        chk("rst_req",   imem_req0,    0);
        chk("rst_sel",   sel0,         0);
        chk("rst_addr",  imem_addr0,   0);
        branch_taken = 1'b0;
        tick();
        rst0 = 1'b1;

        // Edge 1: IDLE -> FETCH
        tick();
        chk("e1_req", imem_req0,    1);
        chk("e1_fv",  fetch_valid0, 0);
        chk("e1_adr", imem_addr0,   0);
        // Edge 2..6: fetch_pc 0..4
        tick();
        chk("e2_fv",  fetch_valid0, 1);
        chk("e2_fpc", fetch_pc0,    0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("seq_fpc", fetch_pc0, i);
            chk("seq_fv",  fetch_valid0, 1);
            chk("seq_sel", sel0, 0);
        end
        chk("seq_adr", imem_addr0, 5);
        chk("seq_inc", pc_inc0, 6);

        // Branch at pc=5 to 100
        branch_taken = 1'b1; tgt = 21'd100;
        #1 chk("br_sel", sel0, 1);
        tick();
        branch_taken = 1'b0;
        chk("br_adr",   imem_addr0,   100);
        chk("br_flush", flush0,       1);
        chk("br_fv",    fetch_valid0, 0);
        tick();
        chk("br_fpc0",   fetch_pc0, 100);
        chk("br_fv1",    fetch_valid0, 1);
        chk("br_flush0", flush0, 0);
        tick();
        chk("br_fpc1", fetch_pc0, 101);
        chk("br_adr2", imem_addr0, 102);

        // Redirect to 7, then stall for 3 cycles
        branch_taken = 1'b1; tgt = 21'd7;
        tick();
        branch_taken = 1'b0;
        chk("b7_adr", imem_addr0, 7);
        stall = 1'b1;
        #1 chk("st_req", imem_req0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("st_adr",   imem_addr0,   7);
            chk("st_fpc",   fetch_pc0,    101);
            chk("st_fv",    fetch_valid0, 0);
            chk("st_req",   imem_req0,    0);
            chk("st_flush", flush0,       0);
        end
        stall = 1'b0;
        tick();
        chk("st_rel_fpc", fetch_pc0, 7);
        chk("st_rel_fv",  fetch_valid0, 1);
        chk("st_rel_adr", imem_addr0, 8);

        // Memory not ready for 2 cycles at pc=8
        imem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("wt_fv",  fetch_valid0, 0);
            chk("wt_adr", imem_addr0,   8);
            chk("wt_req", imem_req0,    1);
        end
        imem_ready = 1'b1;
        tick();
        chk("wt_fpc", fetch_pc0, 8);
        chk("wt_fv1", fetch_valid0, 1);
        chk("wt_adr2", imem_addr0, 9);

        // Stall + branch: branch wins
        stall = 1'b1; branch_taken = 1'b1; tgt = 21'd40;
        #1 chk("sb_sel", sel0, 1);
        tick();
        stall = 1'b0;
        chk("sb_adr",   imem_addr0,   40);
        chk("sb_flush", flush0,       1);
        chk("sb_fv",    fetch_valid0, 0);

        // Halt + branch: halt wins, sel masked
        halt = 1'b1; tgt = 21'd55;
        #1 chk("hb_sel", sel0, 0);
        tick();
        halt = 1'b0; branch_taken = 1'b0;
        chk("h_halted", halted0,      1);
        chk("h_adr",    imem_addr0,   40);
        chk("h_req",    imem_req0,    0);
        chk("h_fv",     fetch_valid0, 0);
        chk("h_flush",  flush0,       0);
        tick(); tick();
        chk("h_sticky", halted0,    1);
        chk("h_adr2",   imem_addr0, 40);
        chk("h_req2",   imem_req0,  0);

        // Asynchronous reset away from a clock edge
        #2 rst0 = 1'b0;
        #1;
        chk("ar_halt", halted0,      0);
        chk("ar_adr",  imem_addr0,   0);
        chk("ar_req",  imem_req0,    0);
        chk("ar_fv",   fetch_valid0, 0);

        // Wrap-around instance
        tick();
        rst1 = 1'b1;
        tick();
        chk("w_adr0", imem_addr1, 21'h1FFFFE);
        chk("w_inc0", pc_inc1,    21'h1FFFFF);
        tick();
        chk("w_fpc0", fetch_pc1,  21'h1FFFFE);
        chk("w_inc1", pc_inc1,    0);
        tick();
        chk("w_fpc1", fetch_pc1,  21'h1FFFFF);
        chk("w_adr1", imem_addr1, 0);
        tick();
        chk("w_fpc2", fetch_pc1,  0);
        chk("w_fv",   fetch_valid1, 1);
        tick();
        chk("w_fpc3", fetch_pc1,  1);
        #2 rst1 = 1'b0;
        #1;
        chk("w_ar_adr", imem_addr1,   21'h1FFFFE);
        chk("w_ar_fv",  fetch_valid1, 0);
        chk("w_ar_fpc", fetch_pc1,    0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
